// File: rtl/led_seq_pkg.sv
// Shared constants for the LED bar / button-sequence lock: segment codes, anode codes,
// button encoding, unlock sequence and FSM states.
package led_seq_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_U     = 8'hC1;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_DIG [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Enum value is the bit position in btn {D,U,R,C,L}
  typedef enum logic [2:0] {
    BTN_L = 3'd0,
    BTN_C = 3'd1,
    BTN_R = 3'd2,
    BTN_U = 3'd3,
    BTN_D = 3'd4
  } btn_e;

  localparam int SEQ_LEN = 6;
  localparam int K_W     = $clog2(SEQ_LEN);
  localparam btn_e SEQ [0:SEQ_LEN-1] = '{BTN_L, BTN_C, BTN_R, BTN_C, BTN_U, BTN_D};

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [4:0] btn_onehot(btn_e b);
    return 5'b00001 << b;
  endfunction

  function automatic logic [7:0] seg_of(btn_e b);
    logic [7:0] s;
    case (b)
      BTN_L:   s = SEG_L;
      BTN_C:   s = SEG_C;
      BTN_R:   s = SEG_R;
      BTN_U:   s = SEG_U;
      BTN_D:   s = SEG_D;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_bar_seq_unlock_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every DIV cycles.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  TC = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TC);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_bar_seq_unlock.sv
// LED bar fill, switch-selected blink and button-sequence unlock with 7-seg prompt.
// Optional idle timeout on the lock is enabled by defining SEQ_TIMEOUT_EN.
module led_bar_seq_unlock
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int N_LED     = 15,
  parameter int FILL_HZ   = 5,
  parameter int BLINK0_HZ = 1,
  parameter int BLINK1_HZ = 10,
  parameter int BLINK2_HZ = 100,
  parameter int TIMEOUT_S = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sw,
  input  logic [4:0]       btn,
  output logic [N_LED-1:0] led,
  output logic [3:0]       an,
  output logic [7:0]       seg,
  output logic             done_led
);

  localparam int CNT_W = $clog2(N_LED + 1);

  logic             fill_tick;
  logic [2:0]       blink_tick, phase_q;
  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [4:0]       btn_q, rise;
  logic             hit;
  logic [N_LED-1:0] lit, fill_mask, led_d;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;

  tick_gen #(.DIV(CLK_HZ / FILL_HZ)) u_fill_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(fill_tick)
  );

  for (genvar i = 0; i < 3; i++) begin : g_blink
    localparam int HZ = (i == 0) ? BLINK0_HZ : (i == 1) ? BLINK1_HZ : BLINK2_HZ;
    tick_gen #(.DIV(CLK_HZ / (2 * HZ))) u_blink_tick (
      .clk_i (clk),
      .rst_i (rst),
      .tick_o(blink_tick[i])
    );
  end

  // btn_q tracks every cycle so a button held across FILL->ARMED never fires
  assign rise = btn & ~btn_q;
  assign hit  = (rise == btn_onehot(SEQ[k_q]));

`ifdef SEQ_TIMEOUT_EN
  localparam int           TO_CYC = TIMEOUT_S * CLK_HZ;
  localparam int           TO_W   = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_TC = TO_W'(TO_CYC - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    k_d   = k_q;
`ifdef SEQ_TIMEOUT_EN
    to_d  = '0;
`endif
    case (st_q)
      FILL: if (fill_tick) begin
        if (cnt_q != CNT_W'(N_LED))   cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_LED-1)) st_d  = ARMED;
      end
      ARMED: begin
        if (hit) begin
          if (k_q == K_W'(SEQ_LEN - 1)) st_d = DONE;
          else                          k_d  = k_q + 1'b1;
        end else if (rise != '0) begin
          k_d = '0;
        end
`ifdef SEQ_TIMEOUT_EN
        // Idle counter restarts on a correct press; on expiry the prompt falls back to SEQ[0]
        if (!hit) begin
          if (to_q == TO_TC) k_d  = '0;
          else               to_d = to_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign fill_mask = ({{(N_LED-1){1'b0}}, 1'b1} << cnt_q) - 1'b1;

  always_comb begin
    lit = '1;
    if      (sw[0]) lit[0] = phase_q[0];
    else if (sw[1]) lit[1] = phase_q[1];
    else if (sw[2]) lit[2] = phase_q[2];
    led_d = lit;
    an_d  = AN_DIG[k_q[1:0]];
    seg_d = seg_of(SEQ[k_q]);
    case (st_q)
      FILL: begin
        led_d = fill_mask;
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
      DONE: begin
        an_d  = AN_DIG[SEQ_LEN % 4];
        seg_d = SEG_C;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= FILL;
      cnt_q    <= '0;
      k_q      <= '0;
      btn_q    <= '0;
      phase_q  <= '0;
      led      <= '0;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
      done_led <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      btn_q    <= btn;
      phase_q  <= phase_q ^ blink_tick;
      led      <= led_d;
      an       <= an_d;
      seg      <= seg_d;
      done_led <= (st_q == DONE);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

endmodule

// File: tb/tb_led_bar_seq_unlock.sv
// Bench for led_bar_seq_unlock at reduced clock rates; reference derived from cycle arithmetic.
module tb_led_bar_seq_unlock;

  localparam int NL     = 15;
  localparam int FILL_D = 10;
  localparam int D0     = 100;
  localparam int D1     = 20;
  localparam int D2     = 10;
  localparam int ARM_N  = 150;
  localparam int TO_CYC = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    sw  = '0;
  logic [4:0]    btn = '0;
  logic [NL-1:0] led;
  logic [3:0]    an;
  logic [7:0]    seg;
  logic          done_led;

  int errs = 0;
  int chks = 0;

  // Reference state: n = edges since reset release, mk = sequence position
  int         n     = 0;
  int         mk    = 0;
  int         idle  = 0;
  bit         mdone = 1'b0;
  logic [4:0] pbtn  = '0;

  int         seq_bit [6] = '{0, 1, 2, 1, 3, 4};
  logic [7:0] letter  [5] = '{8'hC7, 8'hC6, 8'hAF, 8'hC1, 8'hA1};
  logic [3:0] digit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  led_bar_seq_unlock #(
    .CLK_HZ(1000), .N_LED(NL), .FILL_HZ(100),
    .BLINK0_HZ(5), .BLINK1_HZ(25), .BLINK2_HZ(50), .TIMEOUT_S(1)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .led(led), .an(an), .seg(seg), .done_led(done_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_led"},  32'(led),      32'(0));
    check({tag, "_an"},   32'(an),       32'(4'b1111));
    check({tag, "_seg"},  32'(seg),      32'(8'hFF));
    check({tag, "_done"}, 32'(done_led), 32'(0));
  endtask

  // One clock edge: predict outputs from the pre-edge state, then advance the reference
  task automatic step();
    logic [NL-1:0] eled;
    logic [3:0]    ean;
    logic [7:0]    eseg;
    logic [4:0]    rise;
    bit            armed;
    armed = (n >= ARM_N);
    if (!armed) begin
      eled = NL'((1 << (n / FILL_D)) - 1);
      ean  = 4'b1111;
      eseg = 8'hFF;
    end else begin
      eled = '1;
      if      (sw[0]) eled[0] = ((n / D0) % 2) == 1;
      else if (sw[1]) eled[1] = ((n / D1) % 2) == 1;
      else if (sw[2]) eled[2] = ((n / D2) % 2) == 1;
      if (mdone) begin
        ean  = digit[6 % 4];
        eseg = letter[1];
      end else begin
        ean  = digit[mk % 4];
        eseg = letter[seq_bit[mk]];
      end
    end
    @(posedge clk);
    #1;
    check("led",  32'(led),      32'(eled));
    check("an",   32'(an),       32'(ean));
    check("seg",  32'(seg),      32'(eseg));
    check("done", 32'(done_led), 32'(mdone));
    rise = btn & ~pbtn;
    if (armed && !mdone) begin
      if (rise == 5'(1 << seq_bit[mk])) begin
        if (mk == 5) mdone = 1'b1;
        else         mk++;
        idle = 0;
      end else begin
        if (rise != '0) mk = 0;
`ifdef SEQ_TIMEOUT_EN
        if (idle == TO_CYC - 1) begin
          idle = 0;
          mk   = 0;
        end else begin
          idle++;
        end
`endif
      end
    end else begin
      idle = 0;
    end
    pbtn = btn;
    n++;
  endtask

  task automatic press(input logic [4:0] b, input int hold, input int gap);
    btn = b;
    repeat (hold) step();
    btn = '0;
    repeat (gap) step();
  endtask

  task automatic full_seq();
    for (int i = 0; i < 6; i++) press(5'(1 << seq_bit[i]), 1, 2);
  endtask

  initial begin
    logic [4:0] b;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    // Fill with L held from edge 100 to 200, across the FILL->ARMED boundary
    repeat (100) step();
    btn = 5'b00001;
    repeat (100) step();
    btn = '0;
    repeat (5) step();

    sw = 3'b000; repeat (30)  step();
    sw = 3'b001; repeat (250) step();
    sw = 3'b010; repeat (60)  step();
    sw = 3'b100; repeat (30)  step();
    sw = 3'b111; repeat (20)  step();

    // Wrong press and simultaneous edges reset the sequence
    press(5'b00001, 1, 2);
    press(5'b00010, 1, 2);
    press(5'b01100, 1, 2);
    press(5'b00001, 1, 2);
    press(5'b01000, 1, 2);

    for (int i = 0; i < 40; i++) begin
      sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) b = 5'($urandom_range(1, 31));
      else                           b = 5'(1 << $urandom_range(0, 4));
      press(b, $urandom_range(1, 3), $urandom_range(1, 4));
    end

    // Reach k=3, then reset asynchronously mid-cycle
    press(5'b00001, 1, 2);
    press(5'b00010, 1, 2);
    press(5'b00100, 1, 2);
    #3 rst = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; mk = 0; mdone = 1'b0; idle = 0; pbtn = '0;
    sw = 3'($urandom_range(0, 7));
    repeat (160) step();

`ifdef SEQ_TIMEOUT_EN
    press(5'b00001, 1, 2);
    press(5'b00010, 1, 2);
    repeat (1100) step();
`endif

    full_seq();
    repeat (5) step();
    check("unlocked", 32'(done_led), 32'(1));

    for (int i = 0; i < 20; i++) begin
      sw = 3'($urandom_range(0, 7));
      press(5'($urandom_range(0, 31)), $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
